mult4_err_scan: RTL and testbench

MULT4_ERR_SCAN -- requirements
Module: mult4_err_scan

---
 rtl/mult4_err_scan.sv | 146 ++++++++++++++
 tb/tb_mult4_err_scan.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult4_err_scan.sv
// mult4_err_scan: exhaustive 4x4 multiplier error scanner over all 256 operand pairs
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle sweep request, honoured only when idle
//   a_out/b_out  operands driven to the multiplier under test (0 outside the sweep)
//   p_in         product returned by the multiplier under test, DUT_LAT cycles later
//   busy         high from the first sweep cycle through the last drain cycle
//   done         one-cycle pulse when the results are final
//   err_count    number of pairs whose product was wrong
//   sum_abs_err  sum of absolute errors over all pairs
//   max_abs_err  largest absolute error seen
//   max_idx      {A,B} of the first pair that reached max_abs_err
//   bias_sum     signed sum of (p_in - A*B), present only with MULT4_ERR_SCAN_BIAS_EN
// Parameter DUT_LAT (0..3): multiplier latency from a_out/b_out to p_in.
// Optional feature macro: MULT4_ERR_SCAN_BIAS_EN.
module mult4_err_scan #(
    parameter int DUT_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  p_in,
    output logic [3:0]  a_out,
    output logic [3:0]  b_out,
    output logic        busy,
    output logic        done,
    output logic [8:0]  err_count,
    output logic [15:0] sum_abs_err,
    output logic [7:0]  max_abs_err,
    output logic [7:0]  max_idx
`ifdef MULT4_ERR_SCAN_BIAS_EN
    ,
    output logic signed [16:0] bias_sum
`endif
);
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
    state_t state;
    logic [7:0] k;
    logic [1:0] cnt;
    logic sweep, clr, tv;
    logic [7:0] te, ti, d;
    logic [16:0] cur, tap;

    assign sweep = state == SWEEP;
    assign clr = state == IDLE && start;
    assign a_out = sweep ? k[7:4] : 4'd0;
    assign b_out = sweep ? k[3:0] : 4'd0;
    // {valid, expected product, index} travels down the delay line to meet p_in
    assign cur = {sweep, {4'd0, a_out} * {4'd0, b_out}, k};

    generate
        if (DUT_LAT == 0) begin : g_nolat
            assign tap = cur;
        end else begin : g_lat
            logic [16:0] sr [DUT_LAT];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DUT_LAT; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= cur;
                    for (int i = 1; i < DUT_LAT; i++) sr[i] <= sr[i-1];
                end
            end
            assign tap = sr[DUT_LAT-1];
        end
    endgenerate

    assign tv = tap[16];
    assign te = tap[15:8];
    assign ti = tap[7:0];
    assign d = p_in >= te ? p_in - te : te - p_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k <= '0;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= SWEEP;
                    k <= '0;
                    busy <= 1'b1;
                end
                SWEEP: begin
                    k <= k + 8'd1;
                    if (k == 8'hFF) begin
                        if (DUT_LAT == 0) begin
                            state <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            state <= DRAIN;
                            cnt <= 2'(DUT_LAT - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == 2'd0) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else cnt <= cnt - 2'd1;
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            max_idx <= '0;
        end else if (clr) begin
            err_count <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            max_idx <= '0;
        end else if (tv) begin
            err_count <= err_count + {8'd0, d != 8'd0};
            sum_abs_err <= sum_abs_err + {8'd0, d};
            // strict compare keeps the earliest pair on ties
            if (d > max_abs_err) begin
                max_abs_err <= d;
                max_idx <= ti;
            end
        end
    end

`ifdef MULT4_ERR_SCAN_BIAS_EN
    // modulo-2^17 add of the zero-extended difference yields the signed sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bias_sum <= '0;
        else if (clr) bias_sum <= '0;
        else if (tv) bias_sum <= bias_sum + $signed({9'd0, p_in}) - $signed({9'd0, te});
    end
`endif
endmodule

// File: tb/tb_mult4_err_scan.sv
// tb_mult4_err_scan: randomized self-checking bench for mult4_err_scan at latency 0 and 2
module tb_mult4_err_scan;
    logic clk = 0, rst_n = 1, start = 0;
    always #5 clk = ~clk;

    logic [1:0] mode = 0;
    logic mis = 0;
    logic [7:0] noise [256];
    logic [3:0] a0, b0, a2, b2;
    logic [7:0] p0, p2, q1, q2;
    logic busy0, done0, busy2, done2;
    logic [8:0] e0, e2;
    logic [15:0] s0, s2;
    logic [7:0] m0, m2, i0, i2;
    logic [40:0] r0, r2;
    int pass = 0, total = 0;
`ifdef MULT4_ERR_SCAN_BIAS_EN
    logic signed [16:0] bs0, bs2;
`endif

    // multiplier under test: exact, stuck at 0, LSB flipped, or random additive error
    function automatic logic [7:0] f(input logic [1:0] md, input logic [3:0] a, input logic [3:0] b, input logic [7:0] n);
        logic [7:0] x;
        x = {4'd0, a} * {4'd0, b};
        return md == 2'd0 ? x : md == 2'd1 ? 8'd0 : md == 2'd2 ? x ^ 8'd1 : x + n;
    endfunction

    assign p0 = f(mode, a0, b0, noise[{a0, b0}]);
    always @(posedge clk) begin
        q1 <= f(mode, a2, b2, noise[{a2, b2}]);
        q2 <= q1;
    end
    assign p2 = mis ? q1 : q2;
    assign r0 = {e0, s0, m0, i0};
    assign r2 = {e2, s2, m2, i2};

    mult4_err_scan #(.DUT_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .p_in(p0), .a_out(a0), .b_out(b0),
        .busy(busy0), .done(done0), .err_count(e0), .sum_abs_err(s0), .max_abs_err(m0), .max_idx(i0)
`ifdef MULT4_ERR_SCAN_BIAS_EN
        , .bias_sum(bs0)
`endif
    );

    mult4_err_scan #(.DUT_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .p_in(p2), .a_out(a2), .b_out(b2),
        .busy(busy2), .done(done2), .err_count(e2), .sum_abs_err(s2), .max_abs_err(m2), .max_idx(i2)
`ifdef MULT4_ERR_SCAN_BIAS_EN
        , .bias_sum(bs2)
`endif
    );

    task automatic model(output logic [40:0] v, output int bias);
        int ec, sm, mx, ix, e, p, dd;
        ec = 0; sm = 0; mx = 0; ix = 0; bias = 0;
        for (int n = 0; n < 256; n++) begin
            e = (n / 16) * (n % 16);
            p = int'(f(mode, 4'(n / 16), 4'(n % 16), noise[n]));
            dd = p > e ? p - e : e - p;
            ec += dd != 0 ? 1 : 0;
            sm += dd;
            bias += p - e;
            if (dd > mx) begin mx = dd; ix = n; end
        end
        v = {9'(ec), 16'(sm), 8'(mx), 8'(ix)};
    endtask

    task automatic run_sweep(input int ig, output int nb0, output int nb2, output int nd0, output int nd2, output int t0, output int t2);
        @(negedge clk);
        start = 1;
        nb0 = 0; nb2 = 0; nd0 = 0; nd2 = 0; t0 = 0; t2 = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = (c == ig);
            nb0 += int'(busy0);
            nb2 += int'(busy2);
            if (done0) begin nd0++; t0 = c; end
            if (done2) begin nd2++; t2 = c; end
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 0;
        #1;
        if ({busy0, done0, a0, b0, r0, busy2, done2, a2, b2, r2} !== '0)
            $display("FAIL reset outputs got %h/%h want 0", r0, r2);
        else pass++;
        total++;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_pattern(input logic [1:0] md, input string nm);
        logic [40:0] ev;
        int bias, nb0, nb2, nd0, nd2, t0, t2;
        mode = md;
        for (int n = 0; n < 256; n++) noise[n] = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom);
        model(ev, bias);
        run_sweep(0, nb0, nb2, nd0, nd2, t0, t2);
        if (nb0 != 256 || nb2 != 258) $display("FAIL %s busy cycles got %0d/%0d want 256/258", nm, nb0, nb2); else pass++;
        total++;
        if (nd0 != 1 || nd2 != 1 || t0 != 257 || t2 != 259)
            $display("FAIL %s done pulses got %0d@%0d/%0d@%0d want 1@257/1@259", nm, nd0, t0, nd2, t2);
        else pass++;
        total++;
        if (r0 !== ev) $display("FAIL %s lat0 results got %h want %h", nm, r0, ev); else pass++;
        total++;
        if (r2 !== ev) $display("FAIL %s lat2 results got %h want %h", nm, r2, ev); else pass++;
        total++;
        if (md == 2'd1) begin
            if (r0 !== {9'd225, 16'd14400, 8'd225, 8'hFF}) $display("FAIL %s zero constants got %h", nm, r0); else pass++;
            total++;
        end
    endtask

    task automatic test_hold;
        logic [40:0] ev;
        int bias;
        model(ev, bias);
        repeat (20) @(negedge clk);
        if (r0 !== ev || r2 !== ev || {a0, b0, a2, b2, busy0, busy2} !== '0)
            $display("FAIL hold got %h/%h want %h", r0, r2, ev);
        else pass++;
        total++;
    endtask

    task automatic test_misalign;
        int nb0, nb2, nd0, nd2, t0, t2;
        mode = 0;
        mis = 1;
        run_sweep(0, nb0, nb2, nd0, nd2, t0, t2);
        if (e2 == 9'd0) $display("FAIL misalign err_count got %0d want nonzero", e2); else pass++;
        total++;
        if (r0 !== '0) $display("FAIL misalign lat0 got %h want 0", r0); else pass++;
        total++;
        mis = 0;
    endtask

    task automatic test_reset_mid;
        int nb0, nb2, nd0, nd2, t0, t2, nd;
        mode = 1;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (100) @(negedge clk);
        rst_n = 0;
        #1;
        if ({busy0, done0, a0, b0, r0, busy2, done2, a2, b2, r2} !== '0)
            $display("FAIL midreset outputs got %h/%h want 0", r0, r2);
        else pass++;
        total++;
        repeat (2) @(negedge clk);
        rst_n = 1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            nd += int'(done0 | done2 | busy0 | busy2);
        end
        if (nd != 0) $display("FAIL midreset stray activity got %0d want 0", nd); else pass++;
        total++;
        mode = 0;
        run_sweep(0, nb0, nb2, nd0, nd2, t0, t2);
        if (nd0 != 1 || nd2 != 1 || t0 != 257 || t2 != 259 || r0 !== '0 || r2 !== '0)
            $display("FAIL midreset resweep got %0d@%0d/%0d@%0d %h/%h want 1@257/1@259 0", nd0, t0, nd2, t2, r0, r2);
        else pass++;
        total++;
    endtask

    task automatic test_start_ignored;
        int nb0, nb2, nd0, nd2, t0, t2;
        mode = 1;
        run_sweep(51, nb0, nb2, nd0, nd2, t0, t2);
        if (nd0 != 1 || nd2 != 1 || t0 != 257 || t2 != 259 || nb0 != 256 || nb2 != 258)
            $display("FAIL ignored start got %0d@%0d/%0d@%0d busy %0d/%0d", nd0, t0, nd2, t2, nb0, nb2);
        else pass++;
        total++;
        if (r0 !== {9'd225, 16'd14400, 8'd225, 8'hFF} || r2 !== r0)
            $display("FAIL ignored start results got %h/%h", r0, r2);
        else pass++;
        total++;
`ifdef MULT4_ERR_SCAN_BIAS_EN
        if (bs0 !== -17'sd14400 || bs2 !== -17'sd14400)
            $display("FAIL bias_sum got %0d/%0d want -14400", bs0, bs2);
        else pass++;
        total++;
`endif
    endtask

    initial begin
        for (int n = 0; n < 256; n++) noise[n] = 8'd0;
        test_reset;
        test_pattern(2'd0, "exact");
        test_pattern(2'd1, "zero");
        test_hold;
        test_pattern(2'd2, "xor1");
        for (int r = 0; r < 3; r++) test_pattern(2'd3, "random");
        test_misalign;
        test_reset_mid;
        test_start_ignored;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
